key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder_if.sv | 38 +++
 rtl/key_event_decoder.sv | 173 +++++++++++++++++
 tb/tb_key_event_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/key_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder_if
// Description : Key event bus. Carries the debouncer strobe/level into the
//               decoder and the decoded press events back out.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_decoder_if;

  logic key_flag;      // one-cycle strobe: key_value valid this cycle
  logic key_value;     // debounced level, 0 = pressed, 1 = released
  logic short_press;   // pulse: released before the long threshold
  logic long_press;    // pulse: held for the long threshold
  logic repeat_pulse;  // pulse: auto-repeat tick while held long
  logic key_busy;      // level: key currently held

  // Debouncer / stimulus side
  modport master (
    output key_flag,
    output key_value,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  key_busy
  );

  // Decoder side
  modport slave (
    input  key_flag,
    input  key_value,
    output short_press,
    output long_press,
    output repeat_pulse,
    output key_busy
  );

endinterface
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : Classifies debounced key activity into short-press,
//               long-press and (optionally) auto-repeat pulses.
//               Optional feature macro: KEY_REPEAT_EN enables auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
  parameter logic [31:0] LONG_CNT   = 32'd50_000_000,
  parameter logic [31:0] REPEAT_CNT = 32'd10_000_000
) (
  input  wire logic         sys_clk,
  input  wire logic         sys_rst_n,
  key_event_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_hold_cnt;
  logic [31:0] w_hold_cnt_nxt;
  logic [31:0] w_hold_cnt_inc;
  logic        r_short;
  logic        w_short_nxt;
  logic        r_long;
  logic        w_long_nxt;
  logic        r_busy;
  logic        w_busy_nxt;

  logic        w_press;
  logic        w_release;
  logic        w_long_hit;

`ifdef KEY_REPEAT_EN
  logic [31:0] r_rep_cnt;
  logic [31:0] w_rep_cnt_nxt;
  logic [31:0] w_rep_cnt_inc;
  logic        r_repeat;
  logic        w_repeat_nxt;
`else
  // Repeat period has no meaning without auto-repeat; kept visible only so the
  // parameter list stays identical in both builds.
  logic [31:0] w_unused_repeat_cnt;
  assign w_unused_repeat_cnt = REPEAT_CNT;
`endif

  // key_value is only meaningful while the strobe is high
  assign w_press   = bus.key_flag & ~bus.key_value;
  assign w_release = bus.key_flag &  bus.key_value;

  // Saturating increment so a pathological LONG_CNT can never wrap the count
  assign w_hold_cnt_inc = (r_hold_cnt == 32'hFFFF_FFFF) ? r_hold_cnt
                                                        : r_hold_cnt + 32'd1;

  // Counter was cleared on the press edge, so it reads LONG_CNT-1 on the
  // edge that lies LONG_CNT edges after the press-sampling edge.
  assign w_long_hit = (r_hold_cnt >= (LONG_CNT - 32'd1));

`ifdef KEY_REPEAT_EN
  assign w_rep_cnt_inc = (r_rep_cnt == 32'hFFFF_FFFF) ? r_rep_cnt
                                                      : r_rep_cnt + 32'd1;
`endif

  // Next-state, counter and pulse decode; release always wins over thresholds
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_short_nxt    = 1'b0;
    w_long_nxt     = 1'b0;
`ifdef KEY_REPEAT_EN
    w_rep_cnt_nxt  = r_rep_cnt;
    w_repeat_nxt   = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt    = ST_HELD;
          w_hold_cnt_nxt = 32'd0;
        end
      end

      ST_HELD: begin
        if (w_release) begin
          w_short_nxt    = 1'b1;
          w_state_nxt    = ST_IDLE;
          w_hold_cnt_nxt = 32'd0;
        end else if (w_long_hit) begin
          w_long_nxt     = 1'b1;
          w_state_nxt    = ST_LONG_HELD;
          w_hold_cnt_nxt = w_hold_cnt_inc;
`ifdef KEY_REPEAT_EN
          w_rep_cnt_nxt  = 32'd0;
`endif
        end else begin
          // A repeated press strobe lands here too and does not restart
          w_hold_cnt_nxt = w_hold_cnt_inc;
        end
      end

      ST_LONG_HELD: begin
        if (w_release) begin
          w_state_nxt    = ST_IDLE;
          w_hold_cnt_nxt = 32'd0;
`ifdef KEY_REPEAT_EN
          w_rep_cnt_nxt  = 32'd0;
`endif
        end
`ifdef KEY_REPEAT_EN
        else if (r_rep_cnt >= (REPEAT_CNT - 32'd1)) begin
          w_repeat_nxt   = 1'b1;
          w_rep_cnt_nxt  = 32'd0;
        end else begin
          w_rep_cnt_nxt  = w_rep_cnt_inc;
        end
`endif
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_hold_cnt_nxt = 32'd0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, hold counter and registered outputs
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 32'd0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_short    <= w_short_nxt;
      r_long     <= w_long_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counter and pulse register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rep_cnt <= 32'd0;
      r_repeat  <= 1'b0;
    end else begin
      r_rep_cnt <= w_rep_cnt_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign bus.repeat_pulse = r_repeat;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.short_press = r_short;
  assign bus.long_press  = r_long;
  assign bus.key_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Directed self-checking bench for key_event_decoder with
//               LONG_CNT=10, REPEAT_CNT=4. Expected repeat behaviour follows
//               the KEY_REPEAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  key_event_decoder_if bus ();

  key_event_decoder #(
    .LONG_CNT   (32'd10),
    .REPEAT_CNT (32'd4)
  ) u_dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rst_n, key_flag, key_value} applied for one edge, expected outputs after
  typedef struct {
    logic       rst_n;
    logic       flag;
    logic       value;
    logic [3:0] exp;   // {short, long, repeat, busy}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit f, input bit v,
                     input bit s, input bit l, input bit rp, input bit b);
    vec_t t;
    t.rst_n = r; t.flag = f; t.value = v; t.exp = {s, l, rp, b};
    vecs.push_back(t);
  endtask

  // Drive inputs mid-cycle, let one rising edge sample them, settle 1 ns
  task automatic drive(input bit r, input bit f, input bit v);
    @(negedge clk);
    rst_n         = r;
    bus.key_flag  = f;
    bus.key_value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {bus.short_press, bus.long_press, bus.repeat_pulse, bus.key_busy};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: short/long/rep/busy got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.key_flag  = 1'b0;
    bus.key_value = 1'b1;

    // ---- reset state and idle behaviour ----
    add(0,0,1, 0,0,0,0);
    add(0,0,1, 0,0,0,0);
    add(1,1,1, 0,0,0,0);          // release in IDLE ignored
    add(1,0,0, 0,0,0,0);          // level toggle without strobe ignored

    // ---- short press: press edge 0, release edge 5 ----
    add(1,1,0, 0,0,0,1);
    for (int i = 1; i <= 4; i++) add(1,0,0, 0,0,0,1);
    add(1,1,1, 1,0,0,0);
    add(1,0,1, 0,0,0,0);

    // ---- release on the threshold edge 10: release wins ----
    add(1,1,0, 0,0,0,1);
    for (int i = 1; i <= 9; i++) add(1,0,0, 0,0,0,1);
    add(1,1,1, 1,0,0,0);
    add(1,0,1, 0,0,0,0);

    // ---- reset at edge 4 while HELD, release at edge 8 ----
    add(1,1,0, 0,0,0,1);
    for (int i = 1; i <= 3; i++) add(1,0,0, 0,0,0,1);
    add(0,0,0, 0,0,0,0);
    for (int i = 5; i <= 7; i++) add(1,0,0, 0,0,0,0);
    add(1,1,1, 0,0,0,0);
    for (int i = 9; i <= 12; i++) add(1,0,1, 0,0,0,0);

    // ---- reset has priority over a simultaneous press ----
    add(0,1,0, 0,0,0,0);
    for (int i = 0; i < 12; i++) add(1,0,1, 0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].flag, vecs[i].value);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- long hold, release at edge 30 ----
    for (int k = 0; k <= 32; k++) begin
      logic [3:0] e;
      bit rep;
      rep = REP_EN && (k == 14 || k == 18 || k == 22 || k == 26);
      e   = {1'b0, (k == 10), rep, (k < 30)};
      if (k == 0)       drive(1, 1, 0);
      else if (k == 30) drive(1, 1, 1);
      else              drive(1, 0, 0);
      check($sformatf("long_hold_e%0d", k), e);
    end

    // ---- toggles without strobe, re-press at 3, press while long at 11 ----
    for (int k = 0; k <= 14; k++) begin
      logic [3:0] e;
      e = {1'b0, (k == 10), 1'b0, (k < 12)};
      if (k == 0 || k == 3 || k == 11) drive(1, 1, 0);
      else if (k == 12)                drive(1, 1, 1);
      else                             drive(1, 0, k[0]);
      check($sformatf("repress_e%0d", k), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
